// File: rtl/pin_walk_checker.sv
// Fixture-side receiver for the walking-one pin test: locks to the one-hot sweep,
// records stuck/shorted/open pins in a sticky map and counts clean sweeps.
module pin_walk_checker #(
    parameter int unsigned NUM_PINS       = 80,
    parameter int unsigned IDX_W          = 7,
    parameter int unsigned SETTLE_CYCLES  = 250,
    parameter int unsigned TIMEOUT_CYCLES = 75000
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Clear,
    input  logic [NUM_PINS-1:0] Pins_In,
    output logic                Locked,
    output logic                Sample_Valid,
    output logic                Error_Pulse,
    output logic                Fail,
    output logic [NUM_PINS-1:0] Fail_Map,
    output logic [15:0]         Err_Count,
    output logic [15:0]         Sweep_Count,
    output logic                LED_Green,
    output logic                LED_Red
);

    localparam int unsigned STB_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PINS - 1);

    typedef enum logic [1:0] {
        ST_ACQUIRE   = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_WAIT_LOW  = 2'd2
    } state_e;

    logic [NUM_PINS-1:0] pins_meta_q, pins_q, pins_prev_q;
    logic                clr_meta_q, clr_q;
    logic [STB_W-1:0]    stable_q, stable_d;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    expected_q, expected_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                locked_q, locked_d;
    logic                sample_valid_q, sample_valid_d;
    logic                error_pulse_q, error_pulse_d;
    logic                fail_q, fail_d;
    logic [NUM_PINS-1:0] fail_map_q, fail_map_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]    sweep_cnt_q, sweep_cnt_d;
    logic                led_green_q, led_green_d;
    logic                clean_q, clean_d;

    logic                settled_c, timeout_c, pins_nz_c, onehot_c, err_c, advance_c;
    logic [IDX_W-1:0]    hot_idx_c;
    logic [NUM_PINS-1:0] exp_vec_c;

    // Two-flop synchronizers for the asynchronous fixture pins and clear
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pins_meta_q <= '0;
            pins_q      <= '0;
            clr_meta_q  <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            pins_meta_q <= Pins_In;
            pins_q      <= pins_meta_q;
            clr_meta_q  <= Clear;
            clr_q       <= clr_meta_q;
        end
    end

    // Stability counter saturates one past the settle point so each stable period fires once
    always_comb begin
        stable_d = stable_q;
        if (pins_q != pins_prev_q) begin
            stable_d = '0;
        end else if (stable_q != STB_W'(SETTLE_CYCLES)) begin
            stable_d = stable_q + STB_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pins_prev_q <= '0;
            stable_q    <= '0;
        end else begin
            pins_prev_q <= pins_q;
            stable_q    <= stable_d;
        end
    end

    assign settled_c = (stable_q == STB_W'(SETTLE_CYCLES - 1));
    assign timeout_c = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign pins_nz_c = |pins_q;
    assign onehot_c  = $onehot(pins_q);
    assign exp_vec_c = NUM_PINS'(1) << expected_q;

    always_comb begin
        hot_idx_c = '0;
        for (int unsigned i = 0; i < NUM_PINS; i++) begin
            if (pins_q[i]) hot_idx_c = IDX_W'(i);
        end
    end

    always_comb begin
        state_d        = state_q;
        expected_d     = expected_q;
        locked_d       = locked_q;
        timer_d        = (timer_q == TMR_W'(TIMEOUT_CYCLES)) ? timer_q : timer_q + TMR_W'(1);
        fail_map_d     = fail_map_q;
        err_cnt_d      = err_cnt_q;
        sweep_cnt_d    = sweep_cnt_q;
        led_green_d    = led_green_q;
        clean_d        = clean_q;
        sample_valid_d = 1'b0;
        error_pulse_d  = 1'b0;
        err_c          = 1'b0;
        advance_c      = 1'b0;

        case (state_q)
            ST_ACQUIRE: begin
                if (settled_c && pins_nz_c) begin
                    // The locking pulse counts as the sample of its own index
                    if (onehot_c) begin
                        expected_d     = (hot_idx_c == LAST_IDX) ? '0 : hot_idx_c + IDX_W'(1);
                        locked_d       = 1'b1;
                        sample_valid_d = 1'b1;
                    end else begin
                        fail_map_d = fail_map_q | pins_q;
                        err_c      = 1'b1;
                    end
                    state_d = ST_WAIT_LOW;
                    timer_d = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (settled_c && pins_nz_c) begin
                    sample_valid_d = 1'b1;
                    if (pins_q != exp_vec_c) begin
                        fail_map_d = fail_map_q | (pins_q ^ exp_vec_c);
                        err_c      = 1'b1;
                    end
                    advance_c = 1'b1;
                    state_d   = ST_WAIT_LOW;
                    timer_d   = '0;
                end else if (timeout_c) begin
                    fail_map_d = fail_map_q | exp_vec_c;
                    err_c      = 1'b1;
                    advance_c  = 1'b1;
                    timer_d    = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (settled_c && !pins_nz_c) begin
                    state_d = ST_WAIT_HIGH;
                    timer_d = '0;
                end else if (timeout_c && pins_nz_c) begin
                    fail_map_d = fail_map_q | pins_q;
                    err_c      = 1'b1;
                    locked_d   = 1'b0;
                    state_d    = ST_ACQUIRE;
                    timer_d    = '0;
                end
            end
            default: state_d = ST_ACQUIRE;
        endcase

        if (err_c) begin
            clean_d = 1'b0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        // A sweep counts only if no fault was seen since the previous wrap
        if (advance_c) begin
            if (expected_q == LAST_IDX) begin
                expected_d = '0;
                if (clean_q && !err_c) begin
                    sweep_cnt_d = sweep_cnt_q + CNT_W'(1);
                    led_green_d = ~led_green_q;
                end
                clean_d = 1'b1;
            end else begin
                expected_d = expected_q + IDX_W'(1);
            end
        end

        error_pulse_d = err_c;

        if (clr_q) begin
            state_d        = ST_ACQUIRE;
            expected_d     = '0;
            locked_d       = 1'b0;
            timer_d        = '0;
            fail_map_d     = '0;
            err_cnt_d      = '0;
            sweep_cnt_d    = '0;
            led_green_d    = 1'b0;
            clean_d        = 1'b1;
            sample_valid_d = 1'b0;
            error_pulse_d  = 1'b0;
        end

        fail_d = |fail_map_d;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= ST_ACQUIRE;
            expected_q     <= '0;
            timer_q        <= '0;
            locked_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            error_pulse_q  <= 1'b0;
            fail_q         <= 1'b0;
            fail_map_q     <= '0;
            err_cnt_q      <= '0;
            sweep_cnt_q    <= '0;
            led_green_q    <= 1'b0;
            clean_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            expected_q     <= expected_d;
            timer_q        <= timer_d;
            locked_q       <= locked_d;
            sample_valid_q <= sample_valid_d;
            error_pulse_q  <= error_pulse_d;
            fail_q         <= fail_d;
            fail_map_q     <= fail_map_d;
            err_cnt_q      <= err_cnt_d;
            sweep_cnt_q    <= sweep_cnt_d;
            led_green_q    <= led_green_d;
            clean_q        <= clean_d;
        end
    end

    assign Locked       = locked_q;
    assign Sample_Valid = sample_valid_q;
    assign Error_Pulse  = error_pulse_q;
    assign Fail         = fail_q;
    assign Fail_Map     = fail_map_q;
    assign Err_Count    = err_cnt_q;
    assign Sweep_Count  = sweep_cnt_q;
    assign LED_Green    = led_green_q;
    assign LED_Red      = fail_q;

endmodule
